// File: rtl/div_pkg.sv
// div_pkg
//   Shared types and helpers for the signed sequential divider.
//   - div_state_e : FSM state encoding (IDLE, CALC, DONE)
//   - abs_mag     : two's-complement magnitude of a value whose sign is given
//                   separately, so one helper serves any operand width up to
//                   MAX_W. The caller truncates the result to its own width.
//   - most_neg    : bit pattern of the most-negative value for a given width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int MAX_W         = 64;
  localparam int DEFAULT_WIDTH = 8;

  // Negation is taken modulo 2^MAX_W. The low bits therefore hold the magnitude
  // modulo 2^width, so the most-negative value maps onto 2^(width-1).
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                               input logic             negative);
    abs_mag = negative ? -value : value;
  endfunction

  function automatic logic [MAX_W-1:0] most_neg(input int unsigned width);
    most_neg = MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step
//   One combinational restoring-division iteration. This is the single cell of
//   the divider; the top module reuses it once per clock.
//   Ports:
//     rem      in  WIDTH  current partial remainder (always < div_mag)
//     dvd_msb  in  1      next dividend bit shifted into the remainder
//     div_mag  in  WIDTH  divisor magnitude (non-zero)
//     next_rem out WIDTH  partial remainder after this step
//     q_bit    out 1      quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] div_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < div_mag <= 2^(WIDTH-1), so the shifted value fits in WIDTH bits and
  // the extra top bit of the difference acts purely as a borrow/sign flag.
  assign shifted  = {rem, dvd_msb};
  assign diff     = shifted - {1'b0, div_mag};
  assign q_bit    = ~diff[WIDTH];
  assign next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/signed_seq_divider.sv
// signed_seq_divider
//   Iterative two's-complement divider: one restoring step per clock, with
//   valid/ready handshakes on both sides. Quotient truncates toward zero and
//   the remainder takes the sign of the dividend.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     in_valid     operands present          in_ready    high only in IDLE
//     dividend     signed dividend           divisor     signed divisor
//     out_valid    result valid (DONE)       out_ready   consumer takes result
//     quotient     signed quotient           remainder   signed remainder
//     div_by_zero  result from divisor == 0
//     overflow     result from most-negative / -1 (quotient wraps)
module signed_seq_divider
  import div_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  div_state_e       state, next_state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] div_mag_q;
  logic             sign_q;
  logic             sign_r;
  logic             ovf_case;

  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;
  logic [WIDTH-1:0] q_mag_final;
  logic             last_step;
  logic             divisor_zero;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .div_mag  (div_mag_q),
    .next_rem (step_rem),
    .q_bit    (step_q_bit)
  );

  // dvd_q doubles as the quotient register: each step shifts a dividend bit
  // out of the top and the new quotient bit into the bottom.
  assign q_mag_final  = {dvd_q[WIDTH-2:0], step_q_bit};
  assign last_step    = (count == CNT_W'(WIDTH - 1));
  assign divisor_zero = (divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = divisor_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, iteration in CALC, result registers
  // written either at capture (divide by zero) or on the last CALC step.
  // Nothing is written in DONE, which keeps the outputs stable under
  // backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      div_mag_q   <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_case    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q     <= WIDTH'(abs_mag(MAX_W'(dividend), dividend[WIDTH-1]));
            div_mag_q <= WIDTH'(abs_mag(MAX_W'(divisor), divisor[WIDTH-1]));
            sign_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r    <= dividend[WIDTH-1];
            ovf_case  <= (dividend == MOST_NEG) && (divisor == '1);
            rem_q     <= '0;
            count     <= '0;
            if (divisor_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= q_mag_final;
          count <= count + 1'b1;
          // The overflow case needs no special arithmetic: |q| = 2^(WIDTH-1)
          // negates back onto itself and the remainder is already zero.
          if (last_step) begin
            quotient    <= sign_q ? -q_mag_final : q_mag_final;
            remainder   <= sign_r ? -step_rem : step_rem;
            div_by_zero <= 1'b0;
            overflow    <= ovf_case;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider
//   Self-checking bench for signed_seq_divider at WIDTH = 8: directed corner
//   cases, backpressure, reset during a calculation and randomized operands,
//   all checked against a plain-arithmetic reference model.
module tb_signed_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int checkCount = 0;
  int errorCount = 0;

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: the language's own signed integer division already truncates
  // toward zero and gives the remainder the dividend's sign.
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dbz, output logic ovf);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q   = '1;
      r   = a;
      dbz = 1'b1;
      ovf = 1'b0;
    end else begin
      q   = W'(sa / sb);
      r   = W'(sa % sb);
      dbz = 1'b0;
      ovf = (sa == -128) && (sb == -1);
    end
  endtask

  // One full transaction: input handshake, latency measurement, result check,
  // optional backpressure for holdCycles, then the output handshake.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int holdCycles, input string tag);
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    logic         expDbz;
    logic         expOvf;
    int           lat;
    logic         readyStayedLow;
    logic         stable;

    refModel(a, b, expQ, expR, expDbz, expOvf);

    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;

    // Keep in_valid asserted with junk operands while busy: none of it may be
    // taken until the current result has been handed over.
    @(negedge clk);
    lat            = 1;
    readyStayedLow = 1'b1;
    while (!out_valid && lat < 50) begin
      if (in_ready) readyStayedLow = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;

    checkOutput({tag, " latency"}, 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
    checkOutput({tag, " in_ready busy"}, 32'(readyStayedLow), 32'd1);
    checkOutput({tag, " quotient"}, 32'(quotient), 32'(expQ));
    checkOutput({tag, " remainder"}, 32'(remainder), 32'(expR));
    checkOutput({tag, " div_by_zero"}, 32'(div_by_zero), 32'(expDbz));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, " in_ready done"}, 32'(in_ready), 32'd0);

    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      stable = out_valid && !in_ready && (quotient == expQ) && (remainder == expR)
               && (div_by_zero == expDbz) && (overflow == expOvf);
      checkOutput({tag, " hold stable"}, 32'(stable), 32'd1);
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  int dirA [10] = '{100, -100, 100, -100, -128, -128, -128, 5, 0, 127};
  int dirB [10] = '{7, 7, -7, -7, -1, 1, 3, 0, 5, -128};

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    checkOutput("reset flags", 32'({div_by_zero, overflow}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(W'(dirA[i]), W'(dirB[i]), 0, $sformatf("dir%0d", i));
    end

    // Backpressure, then a second transaction straight after release.
    applyStimulus(W'(100), W'(7), 5, "bp1");
    applyStimulus(W'(-57), W'(9), 0, "bp2");

    // Abort a calculation: leave a non-zero result behind first so the
    // asynchronous clear is visible.
    applyStimulus(W'(100), W'(7), 0, "prerst");
    @(negedge clk);
    in_valid = 1'b1;
    dividend = W'(100);
    divisor  = W'(7);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst quotient", 32'(quotient), 32'd0);
    checkOutput("midrst remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst no stale out_valid", 32'(out_valid), 32'd0);
    end
    checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
    applyStimulus(W'(127), W'(127), 0, "postrst");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      applyStimulus(ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/signed_seq_divider.md
Name: signed_seq_divider

Overview:
- Iterative two's-complement divider; the inverse of the team's signed array multiplier.
- Computes quotient and remainder of a signed dividend by a signed divider, one restoring step per clock.
- Sits beside the multiplier in the arithmetic library.
- Valid/ready handshakes on input and output, so it can be dropped into a datapath stage.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: one clock, asynchronous assert, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  divider can accept; high only in IDLE.
- dividend  input  WIDTH  signed dividend.
- divisor  input  WIDTH  signed divisor.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer takes result.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows dividend, |remainder| < |divisor|.
- div_by_zero  output  1  result came from divisor == 0.
- overflow  output  1  result came from most-negative / -1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; counter = 0.
  - quotient, remainder, div_by_zero, overflow = 0.
  - out_valid = 0; in_ready = 1 once rst_n is released.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge E0, capture operands:
    - magnitudes |dividend| and |divisor| as WIDTH-bit unsigned (most-negative maps to 2^(WIDTH-1));
    - sign_q = sign(dividend) XOR sign(divisor); sign_r = sign(dividend);
    - working remainder = 0; counter = 0.
  - If divisor == 0: go to DONE instead of CALC. At E0 register quotient = all ones, remainder = dividend, div_by_zero = 1, overflow = 0.
  - Otherwise go to CALC.
- CALC: one restoring step per edge, MSB-first.
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the divisor magnitude from rem using WIDTH+1 bits.
  - If the result is non-negative: rem = difference and quotient bit = 1; else restore and quotient bit = 0.
  - counter increments each step.
  - At edge E_WIDTH (the WIDTH-th CALC edge):
    - quotient = sign_q ? -q_mag : q_mag, truncated to WIDTH bits;
    - remainder = sign_r ? -r_mag : r_mag;
    - overflow = 1 iff dividend was most-negative and divisor was -1; quotient then wraps to most-negative, remainder = 0;
    - state -> DONE.
- Latency: out_valid rises in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after acceptance. Divide-by-zero takes 1 cycle.
- DONE:
  - out_valid = 1; in_ready = 0.
  - quotient, remainder and flags hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: state -> IDLE, out_valid = 0.
  - Result registers keep their last values; they are don't-care when out_valid is 0.
- No new input is accepted in the handshake cycle. in_ready rises the cycle after the output handshake, so the minimum issue interval is WIDTH+2 cycles.
- in_valid while busy is ignored; operand inputs are not sampled outside IDLE.
- Reset mid-CALC or mid-DONE: the operation is aborted and no out_valid pulse is produced.
- dividend == 0: normal path, result 0 r 0 with no flags.
- All arithmetic is modulo 2^WIDTH except the internal (WIDTH+1)-bit trial subtract.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, CALC, DONE);
  - function abs_mag(WIDTH);
  - constant for the most-negative value.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, dvd MSB, divisor magnitude.
  - Outputs: next rem, quotient bit.
  - It is the cell-level counterpart of the multiplier cells; it is instantiated once and reused each cycle, not unrolled.
- Top holds the FSM, counter, sign registers and output registers.

Test Plan (WIDTH = 8):
- 100 / 7 → quotient 14, remainder 2, flags 0. out_valid exactly 9 cycles after the in handshake; in_ready low throughout.
- -100 / 7 → -14 (0xF2), -2 (0xFE). 100 / -7 → -14, 2. -100 / -7 → 14, -2.
- -128 / -1 → quotient 0x80, remainder 0, overflow 1. -128 / 1 → 0x80, 0, overflow 0. -128 / 3 → -42, -2.
- 5 / 0 → quotient 0xFF, remainder 5, div_by_zero 1. out_valid 1 cycle after acceptance.
- Backpressure:
  - hold out_ready low 5 cycles after out_valid → outputs and out_valid stable; in_ready stays 0.
  - release → out_valid drops the next cycle; in_ready high the same cycle.
  - a second operand pair is then accepted.
- Reset mid-CALC:
  - drop rst_n at CALC step 4 → out_valid, quotient, remainder 0 immediately (asynchronous).
  - after release, in_ready = 1 and 127 / 127 → 1 r 0, with no stale out_valid pulse.
